// File: rtl/mbi5153_pkg.sv
// mbi5153_pkg: command codes, FSM state encodings and HUB mux select values for the frame sequencer
package mbi5153_pkg;
  localparam logic [1:0] CMD_VSYNC  = 2'd0;
  localparam logic [1:0] CMD_PREACT = 2'd1;
  localparam logic [1:0] CMD_WRCFG  = 2'd2;
  localparam logic [3:0] S_IDLE         = 4'd0;
  localparam logic [3:0] S_CFG_PREACT   = 4'd1;
  localparam logic [3:0] S_CFG_WR       = 4'd2;
  localparam logic [3:0] S_LINE_REQ     = 4'd3;
  localparam logic [3:0] S_LINE_WAIT    = 4'd4;
  localparam logic [3:0] S_VS_WAIT      = 4'd5;
  localparam logic [3:0] S_VS_REQ       = 4'd6;
  localparam logic [3:0] S_VS_WAIT_DONE = 4'd7;
  localparam logic [3:0] S_DONE         = 4'd8;
  localparam logic [3:0] S_ERROR        = 4'd9;
  localparam logic OSEL_LINE = 1'b0;
  localparam logic OSEL_CMD  = 1'b1;
endpackage

// File: rtl/mbi5153_watchdog.sv
// mbi5153_watchdog: per-transaction timeout counter, expires on the cycle the count would reach zero
module mbi5153_watchdog #(
  parameter int TIMEOUT = 4096,
  parameter int TO_W = $clog2(TIMEOUT + 1)
) (
  input  logic CLK,
  input  logic RESET,
  input  logic load,
  input  logic run,
  output logic expire
);
  logic [TO_W-1:0] cnt;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) cnt <= '0;
    else if (load) cnt <= TO_W'(TIMEOUT);
    else if (run && cnt != '0) cnt <= cnt - 1'b1;
  assign expire = run && cnt <= TO_W'(1);
endmodule

// File: rtl/mbi5153_frame_ctrl.sv
// mbi5153_frame_ctrl: frame sequencer issuing config, line and VSYNC requests with HUB mux select and watchdog
module mbi5153_frame_ctrl #(
  parameter int NUM_SCAN_LINES = 16,
  parameter int LINE_W = NUM_SCAN_LINES > 1 ? $clog2(NUM_SCAN_LINES) : 1,
  parameter int TIMEOUT = 4096,
  parameter int TO_W = $clog2(TIMEOUT + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FRAME_REQ,
  input  logic              CFG_UPDATE,
  input  logic              VSYNC_OK,
  input  logic              ERR_CLR,
  input  logic              LINE_READY,
  input  logic              LINE_DONE,
  output logic              LINE_REQ,
  output logic [LINE_W-1:0] LINE_NUM,
  input  logic              CMD_READY,
  input  logic              CMD_DONE,
  output logic              CMD_REQ,
  output logic [1:0]        CMD_CODE,
  output logic              OUT_SEL,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              OVERRUN,
  output logic              ERR
);
  import mbi5153_pkg::*;
  logic [3:0] st;
  logic frame_pend, cfg_pend, issued, cfg_st, wd_load, wd_run, wd_exp, done_in, leave_idle, last_line;
  always_comb begin
    cfg_st = st == S_CFG_PREACT || st == S_CFG_WR;
    LINE_REQ = st == S_LINE_REQ && LINE_READY;
    CMD_REQ = ((cfg_st && !issued) || st == S_VS_REQ) && CMD_READY;
    CMD_CODE = st == S_CFG_PREACT ? CMD_PREACT : st == S_CFG_WR ? CMD_WRCFG : CMD_VSYNC;
    OUT_SEL = (cfg_st || st == S_VS_WAIT || st == S_VS_REQ || st == S_VS_WAIT_DONE) ? OSEL_CMD : OSEL_LINE;
    BUSY = st != S_IDLE && st != S_DONE && st != S_ERROR;
    FRAME_DONE = st == S_DONE;
    ERR = st == S_ERROR;
    wd_load = LINE_REQ || CMD_REQ;
    wd_run = st == S_LINE_WAIT || st == S_VS_WAIT_DONE || (cfg_st && issued);
    done_in = st == S_LINE_WAIT ? LINE_DONE : CMD_DONE;
    leave_idle = st == S_IDLE && frame_pend;
    last_line = LINE_NUM == LINE_W'(NUM_SCAN_LINES - 1);
  end
  mbi5153_watchdog #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_wd (
    .CLK(CLK),
    .RESET(RESET),
    .load(wd_load),
    .run(wd_run),
    .expire(wd_exp)
  );
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      st <= S_IDLE;
      LINE_NUM <= '0;
      issued <= 1'b0;
    end else if (wd_exp && !done_in) begin
      st <= S_ERROR;
      issued <= 1'b0;
    end else begin
      case (st)
        S_IDLE: if (frame_pend) begin
          st <= cfg_pend ? S_CFG_PREACT : S_LINE_REQ;
          LINE_NUM <= '0;
        end
        S_CFG_PREACT, S_CFG_WR:
          if (CMD_REQ) issued <= 1'b1;
          else if (issued && CMD_DONE) begin
            issued <= 1'b0;
            st <= st == S_CFG_PREACT ? S_CFG_WR : S_LINE_REQ;
          end
        S_LINE_REQ: if (LINE_READY) st <= S_LINE_WAIT;
        S_LINE_WAIT: if (LINE_DONE) begin
          st <= last_line ? S_VS_WAIT : S_LINE_REQ;
          if (!last_line) LINE_NUM <= LINE_NUM + 1'b1;
        end
        S_VS_WAIT: if (VSYNC_OK) st <= S_VS_REQ;
        S_VS_REQ: if (CMD_READY) st <= S_VS_WAIT_DONE;
        S_VS_WAIT_DONE: if (CMD_DONE) st <= S_DONE;
        S_DONE: begin
          st <= S_IDLE;
          LINE_NUM <= '0;
        end
        S_ERROR: if (ERR_CLR) begin
          st <= S_IDLE;
          LINE_NUM <= '0;
        end
        default: st <= S_IDLE;
      endcase
    end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      frame_pend <= 1'b0;
      cfg_pend <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      frame_pend <= (frame_pend | FRAME_REQ) & ~leave_idle;
      cfg_pend <= CFG_UPDATE | (cfg_pend & ~leave_idle);
      OVERRUN <= OVERRUN | (FRAME_REQ & frame_pend);
    end
endmodule

// File: tb/tb_mbi5153_frame_ctrl.sv
// tb_mbi5153_frame_ctrl: randomized scenario bench with a trace-level frame model
module tb_mbi5153_frame_ctrl;
  localparam int N = 4;
  localparam int TO = 80;
  localparam int LW = 2;
  logic CLK = 0, RESET = 1, FRAME_REQ = 0, CFG_UPDATE = 0, VSYNC_OK = 0, ERR_CLR = 0;
  logic LINE_READY = 0, LINE_DONE = 0, CMD_READY = 0, CMD_DONE = 0;
  logic LINE_REQ, CMD_REQ, OUT_SEL, BUSY, FRAME_DONE, OVERRUN, ERR;
  logic [LW-1:0] LINE_NUM;
  logic [1:0] CMD_CODE;
  int total = 0, bad = 0, cyc = 0, fd_cnt = 0, bad_flags = 0;
  int line_lat = 1, cmd_lat = 0, hold_line = -1;
  bit m_cfg = 0;
  int ev_q[$], cy_q[$], exp_q[$];

  mbi5153_frame_ctrl #(.NUM_SCAN_LINES(N), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .FRAME_REQ(FRAME_REQ), .CFG_UPDATE(CFG_UPDATE), .VSYNC_OK(VSYNC_OK),
    .ERR_CLR(ERR_CLR), .LINE_READY(LINE_READY), .LINE_DONE(LINE_DONE), .LINE_REQ(LINE_REQ),
    .LINE_NUM(LINE_NUM), .CMD_READY(CMD_READY), .CMD_DONE(CMD_DONE), .CMD_REQ(CMD_REQ),
    .CMD_CODE(CMD_CODE), .OUT_SEL(OUT_SEL), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE),
    .OVERRUN(OVERRUN), .ERR(ERR)
  );

  initial forever #5 CLK = ~CLK;
  initial forever begin @(posedge CLK); cyc++; end

  // event recorder: lines as 0..N-1, commands as 100+code, frame completion as 200
  initial forever begin
    @(negedge CLK);
    if (LINE_REQ) begin
      ev_q.push_back(int'(LINE_NUM)); cy_q.push_back(cyc);
      if (!(LINE_READY && !OUT_SEL && !CMD_REQ && !ERR)) bad_flags++;
    end
    if (CMD_REQ) begin
      ev_q.push_back(100 + int'(CMD_CODE)); cy_q.push_back(cyc);
      if (!(CMD_READY && OUT_SEL && CMD_CODE != 2'd3 && !ERR)) bad_flags++;
    end
    if (FRAME_DONE) begin
      ev_q.push_back(200); cy_q.push_back(cyc); fd_cnt++;
      if (BUSY) bad_flags++;
    end
  end

  // line sender model
  initial forever begin
    @(negedge CLK);
    if (LINE_REQ && int'(LINE_NUM) != hold_line) begin
      int lat;
      lat = line_lat != 0 ? line_lat : int'($urandom_range(TO, 1));
      @(posedge CLK);
      repeat (lat - 1) @(posedge CLK);
      #1 LINE_DONE = 1;
      @(posedge CLK);
      #1 LINE_DONE = 0;
    end
  end

  // command sender model
  initial forever begin
    @(negedge CLK);
    if (CMD_REQ) begin
      int lat;
      lat = cmd_lat != 0 ? cmd_lat : int'($urandom_range(20, 1));
      @(posedge CLK);
      repeat (lat - 1) @(posedge CLK);
      #1 CMD_DONE = 1;
      @(posedge CLK);
      #1 CMD_DONE = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL tb_time_limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  task automatic tick(); @(posedge CLK); #1; endtask
  task automatic pulse_frame(); FRAME_REQ = 1; tick(); FRAME_REQ = 0; endtask
  task automatic clear(); ev_q.delete(); cy_q.delete(); exp_q.delete(); fd_cnt = 0; endtask
  task automatic wait_fd(input int target, input int budget, output bit ok);
    for (int i = 0; i < budget && fd_cnt < target; i++) tick();
    ok = fd_cnt >= target;
  endtask
  task automatic wait_ev(input int n, input int budget);
    for (int i = 0; i < budget && ev_q.size() < n; i++) tick();
  endtask
  task automatic model_frame();
    if (m_cfg) begin exp_q.push_back(101); exp_q.push_back(102); end
    for (int i = 0; i < N; i++) exp_q.push_back(i);
    exp_q.push_back(100);
    exp_q.push_back(200);
    m_cfg = 0;
  endtask
  function automatic string tr(input int q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
    return s;
  endfunction
  function automatic int cy_at(input int i);
    return i < cy_q.size() ? cy_q[i] : -1000;
  endfunction
  function automatic logic [10:0] outs();
    return {LINE_REQ, CMD_REQ, OUT_SEL, BUSY, FRAME_DONE, OVERRUN, ERR, LINE_NUM, CMD_CODE};
  endfunction

  task automatic test_reset();
    tick(); tick(); tick();
    total++; if (outs() !== 11'd0) begin bad++; $display("FAIL reset_outputs got=%b want=0", outs()); end
    RESET = 0; tick(); tick();
    total++; if (outs() !== 11'd0) begin bad++; $display("FAIL idle_outputs got=%b want=0", outs()); end
  endtask

  task automatic test_normal();
    int f0; bit ok;
    clear(); LINE_READY = 1; CMD_READY = 1; VSYNC_OK = 1; line_lat = 70; cmd_lat = 0;
    model_frame(); f0 = cyc; pulse_frame(); wait_fd(1, 1000, ok); repeat (5) tick();
    total++; if (!ok) begin bad++; $display("FAIL normal_done got=timeout want=frame_done"); end
    total++; if (tr(ev_q) != tr(exp_q)) begin bad++; $display("FAIL normal_trace got=%s want=%s", tr(ev_q), tr(exp_q)); end
    total++; if (cy_at(0) - f0 !== 2) begin bad++; $display("FAIL normal_latency got=%0d want=2", cy_at(0) - f0); end
    total++; if (cy_at(1) - cy_at(0) !== 71) begin bad++; $display("FAIL normal_spacing got=%0d want=71", cy_at(1) - cy_at(0)); end
    total++; if ({BUSY, OVERRUN, ERR} !== 3'b000) begin bad++; $display("FAIL normal_idle got=%b want=000", {BUSY, OVERRUN, ERR}); end
  endtask

  task automatic test_config();
    bit ok;
    clear(); line_lat = 0;
    CFG_UPDATE = 1; m_cfg = 1; tick(); CFG_UPDATE = 0;
    model_frame(); pulse_frame(); wait_fd(1, 2000, ok);
    model_frame(); pulse_frame(); wait_fd(2, 2000, ok);
    total++; if (!ok || tr(ev_q) != tr(exp_q)) begin bad++; $display("FAIL config_trace got=%s want=%s", tr(ev_q), tr(exp_q)); end
    clear();
    CFG_UPDATE = 1; FRAME_REQ = 1; m_cfg = 1; model_frame(); tick();
    FRAME_REQ = 0; m_cfg = 1; tick(); CFG_UPDATE = 0;
    wait_fd(1, 2000, ok);
    model_frame(); pulse_frame(); wait_fd(2, 2000, ok);
    model_frame(); pulse_frame(); wait_fd(3, 2000, ok);
    total++; if (!ok || tr(ev_q) != tr(exp_q)) begin bad++; $display("FAIL config_race_trace got=%s want=%s", tr(ev_q), tr(exp_q)); end
  endtask

  task automatic test_backpressure();
    int r, rv; bit ok;
    clear(); line_lat = 5; VSYNC_OK = 0;
    model_frame(); pulse_frame(); wait_ev(2, 200);
    LINE_READY = 0; repeat (10) tick(); LINE_READY = 1; r = cyc;
    wait_ev(4, 200); repeat (50) tick();
    total++; if (ev_q.size() !== 4) begin bad++; $display("FAIL vs_hold_events got=%0d want=4", ev_q.size()); end
    total++; if ({OUT_SEL, BUSY} !== 2'b11) begin bad++; $display("FAIL vs_hold_sel_busy got=%b want=11", {OUT_SEL, BUSY}); end
    VSYNC_OK = 1; rv = cyc; wait_fd(1, 500, ok);
    total++; if (!ok || tr(ev_q) != tr(exp_q)) begin bad++; $display("FAIL bp_trace got=%s want=%s", tr(ev_q), tr(exp_q)); end
    total++; if (cy_at(2) !== r) begin bad++; $display("FAIL bp_line_cycle got=%0d want=%0d", cy_at(2), r); end
    total++; if (cy_at(4) !== rv + 1) begin bad++; $display("FAIL bp_vsync_cycle got=%0d want=%0d", cy_at(4), rv + 1); end
  endtask

  task automatic test_timeout();
    int e; bit ok;
    clear(); line_lat = TO;
    model_frame(); pulse_frame(); wait_fd(1, 2000, ok);
    total++; if (!ok || ERR !== 1'b0 || tr(ev_q) != tr(exp_q)) begin bad++; $display("FAIL edge_done_trace got=%s err=%b want=%s err=0", tr(ev_q), ERR, tr(exp_q)); end
    clear(); line_lat = 3; hold_line = 1;
    pulse_frame();
    for (int i = 0; i < TO + 200 && ERR !== 1'b1; i++) tick();
    e = cyc;
    total++; if ({ERR, BUSY} !== 2'b10) begin bad++; $display("FAIL to_err_busy got=%b want=10", {ERR, BUSY}); end
    total++; if (e - cy_at(1) !== TO + 1) begin bad++; $display("FAIL to_cycle got=%0d want=%0d", e - cy_at(1), TO + 1); end
    repeat (20) tick();
    total++; if (ev_q.size() !== 2 || {LINE_REQ, CMD_REQ} !== 2'b00) begin bad++; $display("FAIL to_quiet got=%0d events want=2", ev_q.size()); end
    ERR_CLR = 1; tick(); ERR_CLR = 0;
    total++; if (ERR !== 1'b0) begin bad++; $display("FAIL err_clr got=%b want=0", ERR); end
    hold_line = -1; clear();
    model_frame(); pulse_frame(); wait_fd(1, 2000, ok);
    total++; if (!ok || tr(ev_q) != tr(exp_q)) begin bad++; $display("FAIL to_recover got=%s want=%s", tr(ev_q), tr(exp_q)); end
  endtask

  task automatic test_overrun();
    bit ok;
    clear(); line_lat = 10;
    model_frame(); pulse_frame(); wait_ev(2, 200);
    pulse_frame(); tick();
    total++; if (OVERRUN !== 1'b0) begin bad++; $display("FAIL overrun_single got=%b want=0", OVERRUN); end
    pulse_frame();
    total++; if (OVERRUN !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b want=1", OVERRUN); end
    model_frame(); wait_fd(2, 2000, ok); repeat (200) tick();
    total++; if (!ok || fd_cnt !== 2 || tr(ev_q) != tr(exp_q)) begin bad++; $display("FAIL overrun_trace got=%s want=%s", tr(ev_q), tr(exp_q)); end
    total++; if (OVERRUN !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%b want=1", OVERRUN); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    clear(); line_lat = 10;
    pulse_frame(); wait_ev(3, 200);
    #2 RESET = 1;
    #1;
    total++; if (outs() !== 11'd0) begin bad++; $display("FAIL async_reset got=%b want=0", outs()); end
    tick(); RESET = 0; repeat (100) tick();
    clear(); m_cfg = 0;
    model_frame(); pulse_frame(); wait_fd(1, 2000, ok);
    total++; if (!ok || tr(ev_q) != tr(exp_q)) begin bad++; $display("FAIL restart_trace got=%s want=%s", tr(ev_q), tr(exp_q)); end
  endtask

  task automatic test_random();
    bit ok;
    for (int f = 0; f < 6; f++) begin
      clear(); line_lat = 0; cmd_lat = 0;
      if ($urandom % 2 == 1) begin CFG_UPDATE = 1; m_cfg = 1; tick(); CFG_UPDATE = 0; end
      model_frame(); pulse_frame();
      if ($urandom % 2 == 1) begin wait_ev(1, 300); CFG_UPDATE = 1; tick(); CFG_UPDATE = 0; m_cfg = 1; end
      wait_fd(1, 3000, ok);
      total++; if (!ok || tr(ev_q) != tr(exp_q)) begin bad++; $display("FAIL random_frame%0d got=%s want=%s", f, tr(ev_q), tr(exp_q)); end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_config();
    test_backpressure();
    test_timeout();
    test_overrun();
    test_reset_midframe();
    test_random();
    total++; if (bad_flags !== 0) begin bad++; $display("FAIL request_protocol got=%0d violations want=0", bad_flags); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
